instr_issue: RTL and testbench

- Instruction fetch/issue unit: the initiator side of the controller's start/wait handshake.
- Fetches 16-bit instructions from synchronous instruction memory into an instruction register (IR).
- Drives opcode/ALUop to the controller FSM, pulses s when the controller reports w=1, then waits for the instruction to complete before fetching the next one.
- Sits between instruction memory and the controller FSM.

---
 rtl/risc_pkg.sv | 25 ++
 rtl/instr_issue_if.sv | 26 ++
 rtl/instr_issue.sv | 96 +++++++++
 tb/tb_instr_issue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the instruction issue unit: instruction field positions, HALT opcode, FSM states.
// The HALT state exists only when INSTR_ISSUE_HALT_EN is defined.
package risc_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;

  localparam logic [2:0] HALT_OPC = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MEMWAIT,
    LOAD,
    ISSUE,
    ACK,
    DONE
`ifdef INSTR_ISSUE_HALT_EN
    , HALT
`endif
  } issue_state_t;

endpackage

// File: rtl/instr_issue_if.sv
// Instruction-memory read bus plus the start/wait handshake with the controller FSM.
// The master side is the issue unit; the slave side is memory plus controller.
interface instr_issue_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);

  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic [IW-1:0]   mem_rdata;
  logic            w;
  logic            s;
  logic [2:0]      opcode;
  logic [1:0]      ALUop;

  modport master (
    output mem_rd, mem_addr, s, opcode, ALUop,
    input  mem_rdata, w
  );

  modport slave (
    input  mem_rd, mem_addr, s, opcode, ALUop,
    output mem_rdata, w
  );

endinterface

// File: rtl/instr_issue.sv
// Instruction fetch/issue unit: fetches into IR, pulses s to the controller, waits for completion.
// Define INSTR_ISSUE_HALT_EN to make opcode 3'b111 park the unit in HALT until reset.
module instr_issue
  import risc_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              IW       = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  instr_issue_if.master       bus,
  output logic [IW-1:0]       ir,
  output logic [PC_W-1:0]     pc,
  output logic                busy
`ifdef INSTR_ISSUE_HALT_EN
  , output logic              halted
`endif
);

  issue_state_t state;
  issue_state_t next;
  logic         memRd;
  logic         startPulse;

  // State, IR and PC registers; IR and PC change only in LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == LOAD) begin
        ir <= bus.mem_rdata;
        pc <= pc + PC_W'(1);
      end
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    next       = state;
    memRd      = 1'b0;
    startPulse = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (run) next = FETCH;
      end
      FETCH: begin
        memRd = 1'b1;
        next  = MEMWAIT;
      end
      MEMWAIT: next = LOAD;
      LOAD: begin
`ifdef INSTR_ISSUE_HALT_EN
        if (bus.mem_rdata[OPC_MSB:OPC_LSB] == HALT_OPC) next = HALT;
        else next = ISSUE;
`else
        next = ISSUE;
`endif
      end
      ISSUE: begin
        if (bus.w) begin
          startPulse = 1'b1;
          next       = ACK;
        end
      end
      ACK: begin
        if (!bus.w) next = DONE;
      end
      DONE: begin
        // w high again means the controller finished this instruction
        if (bus.w) next = run ? FETCH : IDLE;
      end
`ifdef INSTR_ISSUE_HALT_EN
      HALT: busy = 1'b0;
`endif
      default: next = IDLE;
    endcase
  end

`ifdef INSTR_ISSUE_HALT_EN
  assign halted = (state == HALT);
`endif

  assign bus.mem_rd   = memRd;
  assign bus.mem_addr = pc;
  assign bus.s        = startPulse;
  assign bus.opcode   = ir[OPC_MSB:OPC_LSB];
  assign bus.ALUop    = ir[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_instr_issue.sv
// Directed self-checking bench for instr_issue; a second instance with RESET_PC=8'hFF covers PC wrap.
// Build with INSTR_ISSUE_HALT_EN defined to exercise the HALT path.
module tb_instr_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        run1, w1, run2, w2;
  logic [15:0] ir1, ir2;
  logic [7:0]  pc1, pc2;
  logic        busy1, busy2;
  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  logic [15:0] rdata1, rdata2;
`ifdef INSTR_ISSUE_HALT_EN
  logic        halted1, halted2;
`endif

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  instr_issue_if #(.PC_W(8), .IW(16)) bus1 ();
  instr_issue_if #(.PC_W(8), .IW(16)) bus2 ();

  assign bus1.mem_rdata = rdata1;
  assign bus1.w         = w1;
  assign bus2.mem_rdata = rdata2;
  assign bus2.w         = w2;

  // Synchronous instruction memories: data valid the cycle after mem_rd
  always @(posedge clk) begin
    if (bus1.mem_rd) rdata1 <= mem1[bus1.mem_addr];
    if (bus2.mem_rd) rdata2 <= mem2[bus2.mem_addr];
  end

  instr_issue #(.PC_W(8), .IW(16), .RESET_PC(8'h00)) dut1 (
    .clk(clk), .reset(reset), .run(run1), .bus(bus1.master),
    .ir(ir1), .pc(pc1), .busy(busy1)
`ifdef INSTR_ISSUE_HALT_EN
    , .halted(halted1)
`endif
  );

  instr_issue #(.PC_W(8), .IW(16), .RESET_PC(8'hFF)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .bus(bus2.master),
    .ir(ir2), .pc(pc2), .busy(busy2)
`ifdef INSTR_ISSUE_HALT_EN
    , .halted(halted2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic rn, input logic wv);
    reset = r;
    run1  = rn;
    w1    = wv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'h0000;
      mem2[i] = 16'h0000;
    end
    mem1[0]   = 16'hD105;
    mem1[1]   = 16'h2A00;
    mem2[255] = 16'h4800;
    rdata1 = '0;
    rdata2 = '0;
    run2 = 1'b0;
    w2   = 1'b1;

    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("rst_s", 32'(bus1.s), 32'h0);
    checkOutput("rst_mem_rd", 32'(bus1.mem_rd), 32'h0);
    checkOutput("rst_busy", 32'(busy1), 32'h0);
    checkOutput("rst_pc", 32'(pc1), 32'h00);
    checkOutput("rst_ir", 32'(ir1), 32'h0000);
    checkOutput("rst_pc2", 32'(pc2), 32'hFF);

    // First instruction with w held high
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("fetch_mem_rd", 32'(bus1.mem_rd), 32'h1);
    checkOutput("fetch_addr", 32'(bus1.mem_addr), 32'h00);
    checkOutput("fetch_busy", 32'(busy1), 32'h1);
    tick();
    checkOutput("memwait_mem_rd", 32'(bus1.mem_rd), 32'h0);
    tick();
    checkOutput("load_s", 32'(bus1.s), 32'h0);
    checkOutput("load_pc", 32'(pc1), 32'h00);
    tick();
    checkOutput("issue_s", 32'(bus1.s), 32'h1);
    checkOutput("issue_ir", 32'(ir1), 32'hD105);
    checkOutput("issue_opcode", 32'(bus1.opcode), 32'h6);
    checkOutput("issue_aluop", 32'(bus1.ALUop), 32'h2);
    checkOutput("issue_pc", 32'(pc1), 32'h01);
    tick();
    checkOutput("ack_s", 32'(bus1.s), 32'h0);
    checkOutput("ack_mem_rd", 32'(bus1.mem_rd), 32'h0);

    // Controller accepts, w low for 4 cycles in DONE
    w1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("done_wait_mem_rd%0d", i), 32'(bus1.mem_rd), 32'h0);
      checkOutput($sformatf("done_wait_s%0d", i), 32'(bus1.s), 32'h0);
    end
    w1 = 1'b1;
    tick();
    checkOutput("refetch_mem_rd", 32'(bus1.mem_rd), 32'h1);
    checkOutput("refetch_addr", 32'(bus1.mem_addr), 32'h01);

    // Controller busy during ISSUE for 5 cycles
    w1 = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("busy_issue_s%0d", i), 32'(bus1.s), 32'h0);
    end
    w1 = 1'b1;
    #1;
    checkOutput("late_issue_s", 32'(bus1.s), 32'h1);
    checkOutput("late_issue_ir", 32'(ir1), 32'h2A00);
    checkOutput("late_issue_opcode", 32'(bus1.opcode), 32'h1);
    checkOutput("late_issue_aluop", 32'(bus1.ALUop), 32'h1);
    tick();
    checkOutput("post_issue_s", 32'(bus1.s), 32'h0);
    checkOutput("post_issue_pc", 32'(pc1), 32'h02);

    // run dropped mid-instruction: completes, then IDLE
    run1 = 1'b0;
    w1   = 1'b0;
    tick();
    checkOutput("run0_done_busy", 32'(busy1), 32'h1);
    w1 = 1'b1;
    tick();
    checkOutput("run0_idle_busy", 32'(busy1), 32'h0);
    checkOutput("run0_idle_mem_rd", 32'(bus1.mem_rd), 32'h0);
    tick();
    checkOutput("run0_stay_mem_rd", 32'(bus1.mem_rd), 32'h0);

    // Reset in the middle of ACK while w is low
    run1 = 1'b1;
    tick();
    tick();
    tick();
    tick();
    checkOutput("pre_rst_issue_s", 32'(bus1.s), 32'h1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("midrst_s", 32'(bus1.s), 32'h0);
    checkOutput("midrst_busy", 32'(busy1), 32'h0);
    checkOutput("midrst_pc", 32'(pc1), 32'h00);
    checkOutput("midrst_ir", 32'(ir1), 32'h0000);
    checkOutput("midrst_mem_rd", 32'(bus1.mem_rd), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // PC wrap on the RESET_PC=8'hFF instance
    run2 = 1'b1;
    tick();
    checkOutput("wrap_fetch_addr", 32'(bus2.mem_addr), 32'hFF);
    checkOutput("wrap_fetch_rd", 32'(bus2.mem_rd), 32'h1);
    tick();
    tick();
    tick();
    checkOutput("wrap_pc", 32'(pc2), 32'h00);
    checkOutput("wrap_ir", 32'(ir2), 32'h4800);
    checkOutput("wrap_issue_s", 32'(bus2.s), 32'h1);
    tick();
    w2 = 1'b0;
    tick();
    w2 = 1'b1;
    tick();
    checkOutput("wrap_refetch_rd", 32'(bus2.mem_rd), 32'h1);
    checkOutput("wrap_refetch_addr", 32'(bus2.mem_addr), 32'h00);
    run2 = 1'b0;

    // Opcode 3'b111: HALT when enabled, ordinary issue otherwise
    mem1[0] = 16'hE000;
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    tick();
    checkOutput("op7_pc", 32'(pc1), 32'h01);
    checkOutput("op7_opcode", 32'(bus1.opcode), 32'h7);
`ifdef INSTR_ISSUE_HALT_EN
    checkOutput("halt_s", 32'(bus1.s), 32'h0);
    checkOutput("halt_flag", 32'(halted1), 32'h1);
    checkOutput("halt_busy", 32'(busy1), 32'h0);
    for (int i = 0; i < 6; i++) begin
      w1 = ~w1;
      tick();
      checkOutput($sformatf("halt_mem_rd%0d", i), 32'(bus1.mem_rd), 32'h0);
      checkOutput($sformatf("halt_s%0d", i), 32'(bus1.s), 32'h0);
      checkOutput($sformatf("halt_hold%0d", i), 32'(halted1), 32'h1);
    end
`else
    checkOutput("op7_issue_s", 32'(bus1.s), 32'h1);
    checkOutput("op7_busy", 32'(busy1), 32'h1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
